// File: rtl/rf_pkg.sv
// Shared constants and type helpers for the multi-port register file.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Architectural zero register: hardwired to zero, never written or reserved.
  localparam int ZERO_REG  = 0;

  typedef logic [$clog2(NREGS_DEF)-1:0] addr_t;
  typedef logic [XLEN_DEF-1:0]          data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one pending-result bit per register plus a sticky
// protocol-error flag for reservation / long-latency writeback misuse.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             wb1_en,
  input  logic [AW-1:0]    wb1_addr,
  input  logic             wb0_en,
  input  logic [AW-1:0]    wb0_addr,
  output logic [NREGS-1:0] busy,
  output logic             sb_err
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic             err_reg;
  logic             err_next;

  logic rsv_do;
  logic wb1_do;
  logic wb0_do;
  logic rsv_err;
  logic wb1_err;
  logic wb0_err;

  assign rsv_do = rsv_en && (rsv_addr != ZERO_ADDR);
  assign wb1_do = wb1_en && (wb1_addr != ZERO_ADDR);
  assign wb0_do = wb0_en && (wb0_addr != ZERO_ADDR);

  // Protocol checks use the busy state before this edge's updates.
  always_comb begin
    rsv_err = rsv_do && busy_reg[rsv_addr] && !(wb1_en && (wb1_addr == rsv_addr));
    wb1_err = wb1_do && !busy_reg[wb1_addr];
    wb0_err = wb0_do && busy_reg[wb0_addr];
    err_next = err_reg | rsv_err | wb1_err | wb0_err;
  end

  // Next busy vector: release first, so a same-cycle reservation wins.
  always_comb begin
    busy_next = busy_reg;
    if (wb1_do) begin
      busy_next[wb1_addr] = 1'b0;
    end
    if (rsv_do) begin
      busy_next[rsv_addr] = 1'b1;
    end
    busy_next[ZERO_REG] = 1'b0;
  end

  // Scoreboard state register; reset drops all pending reservations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      err_reg  <= err_next;
    end
  end

  assign busy   = busy_reg;
  assign sb_err = err_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD combinational read ports, an ALU
// writeback port (WB0, wins on conflicts), a long-latency writeback port (WB1)
// and a busy scoreboard so decode can stall on pending long-latency results.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wb0_en,
  input  logic [AW-1:0]          wb0_addr,
  input  logic [XLEN-1:0]        wb0_data,
  input  logic                   wb1_en,
  input  logic [AW-1:0]          wb1_addr,
  input  logic [XLEN-1:0]        wb1_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  output logic                   sb_err
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [XLEN-1:0]  regs_reg [NREGS];
  logic [NREGS-1:0] busy;
  logic             wb0_do;
  logic             wb1_do;

  assign wb0_do = wb0_en && (wb0_addr != ZERO_ADDR);
  assign wb1_do = wb1_en && (wb1_addr != ZERO_ADDR);

  // Register storage; WB0 is applied last so it wins a same-address conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      if (wb1_do) begin
        regs_reg[wb1_addr] <= wb1_data;
      end
      if (wb0_do) begin
        regs_reg[wb0_addr] <= wb0_data;
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wb1_en   (wb1_en),
    .wb1_addr (wb1_addr),
    .wb0_en   (wb0_en),
    .wb0_addr (wb0_addr),
    .busy     (busy),
    .sb_err   (sb_err)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rdata_p;
      logic            rbusy_p;

      assign ra = rd_addr[gi*AW +: AW];

      // Read mux: zero register first, then WB0, then WB1 bypass, then storage.
      always_comb begin
        rdata_p = regs_reg[ra];
        rbusy_p = busy[ra];
        if (BYPASS != 0) begin
          if (wb1_en && (wb1_addr == ra)) begin
            rdata_p = wb1_data;
            rbusy_p = 1'b0;
          end
          if (wb0_en && (wb0_addr == ra)) begin
            rdata_p = wb0_data;
          end
        end
        if (ra == ZERO_ADDR) begin
          rdata_p = '0;
          rbusy_p = 1'b0;
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = rdata_p;
      assign rd_busy[gi]              = rbusy_p;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing and a non-bypassing instance share all
// inputs; an abstract model predicts every output each cycle, and directed
// literal checks pin the model to hand-computed values.
module tb_regfile_mp;
  import rf_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra0, ra1;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        sb_err_a, sb_err_b;
  logic        wb0_en, wb1_en, rsv_en;
  addr_t       wb0_addr, wb1_addr, rsv_addr;
  data_t       wb0_data, wb1_data;

  int checks = 0;
  int failures = 0;

  assign rd_addr = {ra1, ra0};

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .sb_err(sb_err_a)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .sb_err(sb_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit [31:0] m_mem  [32];
  bit        m_busy [32];
  bit        m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      if (rsv_en && rsv_addr != 0 && m_busy[rsv_addr] && !(wb1_en && wb1_addr == rsv_addr)) m_err = 1'b1;
      if (wb1_en && wb1_addr != 0 && !m_busy[wb1_addr]) m_err = 1'b1;
      if (wb0_en && wb0_addr != 0 && m_busy[wb0_addr]) m_err = 1'b1;
      if (wb1_en && wb1_addr != 0) m_mem[wb1_addr] = wb1_data;
      if (wb0_en && wb0_addr != 0) m_mem[wb0_addr] = wb0_data;
      if (wb1_en) m_busy[wb1_addr] = 1'b0;
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 0) return 32'h0;
    if (byp && wb0_en && wb0_addr == a) return wb0_data;
    if (byp && wb1_en && wb1_addr == a) return wb1_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 0) return 1'b0;
    if (byp && wb1_en && wb1_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("a.rd0", rd_data_a[31:0],  exp_data(ra0, 1'b1));
    chk("a.rd1", rd_data_a[63:32], exp_data(ra1, 1'b1));
    chk("b.rd0", rd_data_b[31:0],  exp_data(ra0, 1'b0));
    chk("b.rd1", rd_data_b[63:32], exp_data(ra1, 1'b0));
    chk("a.busy", {30'h0, rd_busy_a}, {30'h0, exp_busy(ra1, 1'b1), exp_busy(ra0, 1'b1)});
    chk("b.busy", {30'h0, rd_busy_b}, {30'h0, exp_busy(ra1, 1'b0), exp_busy(ra0, 1'b0)});
    chk("a.err", {31'h0, sb_err_a}, {31'h0, m_err});
    chk("b.err", {31'h0, sb_err_b}, {31'h0, m_err});
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                      input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                      input logic re, input logic [4:0] rsa,
                      input logic [4:0] a0, input logic [4:0] a1);
    @(posedge clk);
    #1;
    wb0_en = w0e; wb0_addr = w0a; wb0_data = w0d;
    wb1_en = w1e; wb1_addr = w1a; wb1_data = w1d;
    rsv_en = re;  rsv_addr = rsa;
    ra0 = a0; ra1 = a1;
    $display("txn t=%0t rst_n=%0b wb0=%0b/%0d/%h wb1=%0b/%0d/%h rsv=%0b/%0d rd=%0d,%0d",
             $time, rst_n, w0e, w0a, w0d, w1e, w1a, w1d, re, rsa, a0, a1);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    step(0, 0, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    wb0_en = 0; wb0_addr = 0; wb0_data = 0;
    wb1_en = 0; wb1_addr = 0; wb1_data = 0;
    rsv_en = 0; rsv_addr = 0; ra0 = 0; ra1 = 0;
    idle(0, 5);
    chk("lit.reset_rd", rd_data_a[63:32], 32'h0);
    chk("lit.reset_err", {31'h0, sb_err_a}, 32'h0);
    rst_n = 1'b1;

    // Write r5, then asynchronous reset between clock edges.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    chk("lit.byp_r5_a", rd_data_a[31:0], 32'hDEADBEEF);
    chk("lit.byp_r5_b", rd_data_b[31:0], 32'h0);
    idle(5, 5);
    chk("lit.r5_stored", rd_data_b[63:32], 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("lit.async_rst_rd_a", rd_data_a[31:0], 32'h0);
    chk("lit.async_rst_rd_b", rd_data_b[31:0], 32'h0);
    chk("lit.async_rst_busy", {30'h0, rd_busy_a}, 32'h0);
    chk("lit.async_rst_err", {31'h0, sb_err_a}, 32'h0);
    idle(5, 0);
    rst_n = 1'b1;

    // Zero register: write and reserve r0.
    step(1, 0, 32'h1234, 0, 0, 0, 1, 0, 0, 0);
    chk("lit.r0_same", rd_data_a[31:0], 32'h0);
    idle(0, 0);
    chk("lit.r0_next", rd_data_b[31:0], 32'h0);
    chk("lit.r0_busy", {30'h0, rd_busy_a}, 32'h0);
    chk("lit.r0_err", {31'h0, sb_err_a}, 32'h0);

    // Bypass of a pending long-latency result.
    step(1, 3, 32'h11, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    step(0, 0, 0, 1, 3, 32'h42, 0, 0, 3, 0);
    chk("lit.byp_r3_a", rd_data_a[31:0], 32'h42);
    chk("lit.byp_r3_b", rd_data_b[31:0], 32'h11);
    idle(3, 3);
    chk("lit.r3_next_b", rd_data_b[63:32], 32'h42);
    chk("lit.r3_err", {31'h0, sb_err_b}, 32'h0);

    // Scoreboard set / same-cycle release / reserve-and-release together.
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 3);
    idle(9, 9);
    chk("lit.r9_busy_a", {30'h0, rd_busy_a}, 32'h3);
    chk("lit.r9_busy_b", {30'h0, rd_busy_b}, 32'h3);
    step(0, 0, 0, 1, 9, 32'h77, 0, 0, 9, 0);
    chk("lit.r9_rel_a", {31'h0, rd_busy_a[0]}, 32'h0);
    chk("lit.r9_rel_b", {31'h0, rd_busy_b[0]}, 32'h1);
    chk("lit.r9_data_a", rd_data_a[31:0], 32'h77);
    idle(9, 0);
    chk("lit.r9_clear", {31'h0, rd_busy_b[0]}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    step(0, 0, 0, 1, 9, 32'h88, 1, 9, 9, 9);
    idle(9, 9);
    chk("lit.r9_rebusy", {30'h0, rd_busy_a}, 32'h3);
    chk("lit.r9_88", rd_data_b[31:0], 32'h88);
    chk("lit.r9_noerr", {31'h0, sb_err_a}, 32'h0);

    // Dual write conflict: WB0 wins (also raises sb_err, wb1 to non-busy r7).
    step(1, 7, 32'hAAAA0000, 1, 7, 32'h5555FFFF, 0, 0, 7, 7);
    chk("lit.dual_same_p0", rd_data_a[31:0], 32'hAAAA0000);
    chk("lit.dual_same_p1", rd_data_a[63:32], 32'hAAAA0000);
    idle(7, 7);
    chk("lit.dual_next_b0", rd_data_b[31:0], 32'hAAAA0000);
    chk("lit.dual_next_b1", rd_data_b[63:32], 32'hAAAA0000);
    chk("lit.dual_err", {31'h0, sb_err_a}, 32'h1);

    // Double reservation.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    idle(4, 0);
    chk("lit.dbl_rsv_err", {31'h0, sb_err_a}, 32'h1);
    idle(0, 0);
    chk("lit.dbl_rsv_sticky", {31'h0, sb_err_b}, 32'h1);

    // WB1 to a non-busy register.
    do_reset();
    chk("lit.err_cleared", {31'h0, sb_err_a}, 32'h0);
    step(0, 0, 0, 1, 6, 32'h1, 0, 0, 6, 0);
    idle(6, 0);
    chk("lit.wb1_nb_err", {31'h0, sb_err_a}, 32'h1);
    chk("lit.wb1_nb_data", rd_data_b[31:0], 32'h1);

    // WAW: WB0 to a reserved register; the write still lands.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1, 8, 8, 0);
    step(1, 8, 32'h5, 0, 0, 0, 0, 0, 8, 0);
    idle(8, 8);
    chk("lit.waw_err", {31'h0, sb_err_b}, 32'h1);
    chk("lit.waw_data", rd_data_a[63:32], 32'h5);
    chk("lit.waw_busy", {30'h0, rd_busy_a}, 32'h3);

    idle(0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
